seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Downstream display stage of the clock. Takes the 12-bit display word produced by the time/mode
//  logic and drives a 4-digit multiplexed 7-segment display. Converts binary to BCD with a
//  sequential double-dabble, rotates one-hot digit enables and applies PWM dimming per digit slot.
// PARAMETERS
//  SCAN_DIV        1024  clock cycles per digit slot; multiple of 8, >= 8
//  SEG_ACTIVE_LOW  0     1: invert segment[6:0] at the output register
//  DIG_ACTIVE_LOW  0     1: invert bytee[3:0] at the output register
// PORTS
//  clock        in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  data_show    in   12  [11]=split flag; split: [10:6] hi field, [5:0] lo field; else [10:0] one value
//  byte_status  in   3   brightness 0..7 (7 = full on)
//  segment      out  7   {g,f,e,d,c,b,a}, bit0 = a
//  bytee        out  4   one-hot digit enable, bit0 = rightmost digit
//  conv_busy    out  1   high while the BCD converter is running
// BEHAVIOUR
//  Reset (sync, active-high): slot_cnt=0, dig_idx=0, all four digit registers=BLANK, FSM=IDLE;
//   segment=all off, bytee=none active, conv_busy=0 (after polarity parameters applied).
//  Scan: slot_cnt counts 0..SCAN_DIV-1, then wraps and dig_idx advances 0->1->2->3->0.
//   Frame start = slot_cnt==0 && dig_idx==0, including the first cycle after reset deasserts.
//  Capture: at frame start, if FSM==IDLE, latch data_show into a holding register and start
//   conversion. If busy, skip the capture for that frame. data_show is ignored between captures.
//  FSM states: IDLE -> CONV_A -> [CONV_B] -> LOAD -> IDLE.
//   CONV_A: 11 shift cycles, 11-bit zero-extended operand. Split mode uses the lo field; otherwise
//    the whole [10:0] value.
//   CONV_B: split mode only; 11 shift cycles on the hi field.
//   LOAD: 1 cycle; all four digit registers update together, so the display never shows a
//    partially updated value.
//   Latency from capture to new digits: 12 cycles (whole mode), 23 cycles (split mode).
//   conv_busy=1 in CONV_A, CONV_B and LOAD.
//  Digit contents:
//   Split mode: digits 3:2 = hi field as 2 BCD digits (0..31); digits 1:0 = lo field as 2 BCD
//    digits (0..63). No zero blanking, so hi=0, lo=5 shows "0005".
//   Whole mode: 4 BCD digits of 0..2047. Leading zeros are blanked; digit 0 is never blanked.
//  Decode: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. BLANK = 00.
//  Dimming: a digit is lit while slot_cnt < ((byte_status+1)*SCAN_DIV)>>3. Outside that window
//   bytee=none and segment=00. byte_status is sampled every cycle.
//  Outputs are registered and reflect the slot_cnt/dig_idx state of the previous cycle
//   (1-cycle latency).
//  Reset mid-conversion: the conversion aborts, the digits go BLANK, and a new capture occurs
//   at the first frame start after release.
// TESTING (bench uses SCAN_DIV=8)
//  1 Hold reset for 3 cycles -> segment=00, bytee=0000 during reset. First capture on the first
//    post-reset cycle. Digits stay blank until LOAD.
//  2 data_show={1,5'd12,6'd34}, byte_status=7 -> after 23 cycles, frames show digits 3..0 =
//    1,2,3,4 (segment 06,5B,4F,66). bytee cycles 0001,0010,0100,1000 every 8 cycles.
//  3 data_show=12'd123 (split=0) -> digits 3..0 = BLANK,1,2,3. data_show=0 -> only digit0 lit, 3F.
//  4 byte_status=0/3/7 -> each digit lit for 1/4/8 of its 8 slot cycles. Otherwise bytee=0000, segment=00.
//  5 Assert reset 5 cycles into CONV_A -> conv_busy=0 and digits BLANK. After release, the new
//    value appears 12/23 cycles after the next frame start.
//  6 Change data_show from 12'd7 to 12'd9 during CONV_A -> "7" is displayed for the rest of the
//    frame; "9" appears only after the next frame's conversion.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed 7-segment driver: sequential double-dabble BCD conversion,
// one-hot digit scan with per-slot PWM dimming, registered outputs.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV       = 1024,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] data_show,
    input  logic [2:0]  byte_status,
    output logic [6:0]  segment,
    output logic [3:0]  bytee,
    output logic        conv_busy
);

    localparam int unsigned   CW        = $clog2(SCAN_DIV);
    localparam int unsigned   SLOT_UNIT = SCAN_DIV / 8;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONV_A, CONV_B, LOAD} state_t;

    function automatic logic [15:0] dd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    logic [CW-1:0]   slot_cnt_q, slot_cnt_d;
    logic [1:0]      dig_idx_q, dig_idx_d;
    state_t          state_q, state_d;
    logic            split_q, split_d;
    logic [4:0]      hi_q, hi_d;
    logic [10:0]     op_q, op_d;
    logic [15:0]     bcd_q, bcd_d;
    logic [7:0]      res_lo_q, res_lo_d;
    logic [3:0]      shift_cnt_q, shift_cnt_d;
    logic [3:0][6:0] dig_seg_q, dig_seg_d;
    logic [6:0]      segment_q, segment_d;
    logic [3:0]      bytee_q, bytee_d;
    logic            conv_busy_q, conv_busy_d;

    logic            frame_start;
    logic [26:0]     shifted;
    logic [15:0]     bcd_shift;
    logic [10:0]     op_shift;
    logic            last_shift;
    logic            blank3, blank2, blank1;
    logic [CW:0]     lit_thr;
    logic            lit;

    always_comb begin
        slot_cnt_d  = slot_cnt_q;
        dig_idx_d   = dig_idx_q;
        state_d     = state_q;
        split_d     = split_q;
        hi_d        = hi_q;
        op_d        = op_q;
        bcd_d       = bcd_q;
        res_lo_d    = res_lo_q;
        shift_cnt_d = shift_cnt_q;
        dig_seg_d   = dig_seg_q;

        if (slot_cnt_q == SLOT_LAST) begin
            slot_cnt_d = '0;
            dig_idx_d  = dig_idx_q + 2'd1;
        end else begin
            slot_cnt_d = slot_cnt_q + 1'b1;
        end
        frame_start = (slot_cnt_q == '0) && (dig_idx_q == '0);

        // One double-dabble step: add-3 correction, then shift operand MSB into the BCD field.
        shifted    = {dd_adjust(bcd_q), op_q} << 1;
        bcd_shift  = shifted[26:11];
        op_shift   = shifted[10:0];
        last_shift = (shift_cnt_q == 4'd10);

        blank3 = (bcd_q[15:12] == 4'd0);
        blank2 = blank3 && (bcd_q[11:8] == 4'd0);
        blank1 = blank2 && (bcd_q[7:4] == 4'd0);

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    split_d     = data_show[11];
                    hi_d        = data_show[10:6];
                    op_d        = data_show[11] ? {5'd0, data_show[5:0]} : data_show[10:0];
                    bcd_d       = '0;
                    shift_cnt_d = '0;
                    state_d     = CONV_A;
                end
            end
            CONV_A: begin
                bcd_d       = bcd_shift;
                op_d        = op_shift;
                shift_cnt_d = shift_cnt_q + 4'd1;
                if (last_shift) begin
                    shift_cnt_d = '0;
                    if (split_q) begin
                        // Park the lo-field result and restart the shifter on the hi field.
                        res_lo_d = bcd_shift[7:0];
                        bcd_d    = '0;
                        op_d     = {6'd0, hi_q};
                        state_d  = CONV_B;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            CONV_B: begin
                bcd_d       = bcd_shift;
                op_d        = op_shift;
                shift_cnt_d = shift_cnt_q + 4'd1;
                if (last_shift) begin
                    shift_cnt_d = '0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (split_q) begin
                    dig_seg_d = {seg_decode(bcd_q[7:4]), seg_decode(bcd_q[3:0]),
                                 seg_decode(res_lo_q[7:4]), seg_decode(res_lo_q[3:0])};
                end else begin
                    dig_seg_d = {blank3 ? 7'h00 : seg_decode(bcd_q[15:12]),
                                 blank2 ? 7'h00 : seg_decode(bcd_q[11:8]),
                                 blank1 ? 7'h00 : seg_decode(bcd_q[7:4]),
                                 seg_decode(bcd_q[3:0])};
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        lit_thr     = (CW+1)'((32'(byte_status) + 32'd1) * SLOT_UNIT);
        lit         = ({1'b0, slot_cnt_q} < lit_thr);
        segment_d   = (lit ? dig_seg_q[dig_idx_q] : 7'h00) ^ {7{SEG_ACTIVE_LOW}};
        bytee_d     = (lit ? (4'b0001 << dig_idx_q) : 4'b0000) ^ {4{DIG_ACTIVE_LOW}};
        conv_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_cnt_q  <= '0;
            dig_idx_q   <= '0;
            state_q     <= IDLE;
            split_q     <= 1'b0;
            hi_q        <= '0;
            op_q        <= '0;
            bcd_q       <= '0;
            res_lo_q    <= '0;
            shift_cnt_q <= '0;
            dig_seg_q   <= '0;
            segment_q   <= {7{SEG_ACTIVE_LOW}};
            bytee_q     <= {4{DIG_ACTIVE_LOW}};
            conv_busy_q <= 1'b0;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            dig_idx_q   <= dig_idx_d;
            state_q     <= state_d;
            split_q     <= split_d;
            hi_q        <= hi_d;
            op_q        <= op_d;
            bcd_q       <= bcd_d;
            res_lo_q    <= res_lo_d;
            shift_cnt_q <= shift_cnt_d;
            dig_seg_q   <= dig_seg_d;
            segment_q   <= segment_d;
            bytee_q     <= bytee_d;
            conv_busy_q <= conv_busy_d;
        end
    end

    assign segment   = segment_q;
    assign bytee     = bytee_q;
    assign conv_busy = conv_busy_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (SCAN_DIV=8): expectations are queued per clock
// cycle by the stimulus and checked by an independent monitor on the falling edge.
module tb_seg7_scan_driver;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] data_show;
    logic [2:0]  byte_status;
    logic [6:0]  segment;
    logic [3:0]  bytee;
    logic        conv_busy;

    seg7_scan_driver #(
        .SCAN_DIV       (8),
        .SEG_ACTIVE_LOW (1'b0),
        .DIG_ACTIVE_LOW (1'b0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .data_show   (data_show),
        .byte_status (byte_status),
        .segment     (segment),
        .bytee       (bytee),
        .conv_busy   (conv_busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        string      name;
        bit         chk_disp;
        logic [6:0] seg;
        logic [3:0] dig;
        bit         chk_busy;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push_exp(input exp_t e);
        int i = 0;
        while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
        sb.insert(i, e);
    endtask

    task automatic exp_disp(input int c, input string nm, input logic [6:0] s, input logic [3:0] d);
        exp_t e;
        e = '{cyc: c, name: nm, chk_disp: 1'b1, seg: s, dig: d, chk_busy: 1'b0, busy: 1'b0};
        push_exp(e);
    endtask

    task automatic exp_busy(input int c, input string nm, input logic b);
        exp_t e;
        e = '{cyc: c, name: nm, chk_disp: 1'b0, seg: 7'h00, dig: 4'h0, chk_busy: 1'b1, busy: b};
        push_exp(e);
    endtask

    // A full frame starting at dig0/slot0 with fixed digit patterns and lit window thr.
    task automatic exp_frame(input int base, input string nm, input logic [6:0] s3,
                             input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0,
                             input int thr);
        logic [6:0] sv [4];
        sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
        for (int d = 0; d < 4; d++) begin
            for (int s = 0; s < 8; s++) begin
                if (s < thr)
                    exp_disp(base + 8*d + s, $sformatf("%s d%0d s%0d", nm, d, s), sv[d], 4'(1 << d));
                else
                    exp_disp(base + 8*d + s, $sformatf("%s d%0d s%0d", nm, d, s), 7'h00, 4'b0000);
            end
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    always @(negedge clock) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.cyc != cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: check for cycle %0d reached at cycle %0d", mon_e.name, mon_e.cyc, cyc);
            end else begin
                if (mon_e.chk_disp) begin
                    n_cmp++;
                    if (segment !== mon_e.seg || bytee !== mon_e.dig) begin
                        n_bad++;
                        $display("FAIL %s @%0d: segment=%h bytee=%b, required segment=%h bytee=%b",
                                 mon_e.name, cyc, segment, bytee, mon_e.seg, mon_e.dig);
                    end
                end
                if (mon_e.chk_busy) begin
                    n_cmp++;
                    if (conv_busy !== mon_e.busy) begin
                        n_bad++;
                        $display("FAIL %s @%0d: conv_busy=%b, required %b",
                                 mon_e.name, cyc, conv_busy, mon_e.busy);
                    end
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        data_show   = {1'b1, 5'd12, 6'd34};
        byte_status = 3'd7;

        // Reset held over posedges 1..3; capture at posedge 4, split LOAD result at posedge 27.
        for (int c = 1; c <= 3; c++) begin
            exp_disp(c, "reset outputs", 7'h00, 4'b0000);
            exp_busy(c, "reset busy", 1'b0);
        end
        exp_disp(4,  "first slot blank", 7'h00, 4'b0001);
        exp_busy(4,  "capture starts conv", 1'b1);
        exp_disp(20, "blank before load", 7'h00, 4'b0100);
        exp_busy(26, "split load busy", 1'b1);
        exp_busy(27, "split done", 1'b0);
        exp_disp(27, "split latency edge", 7'h00, 4'b0100);
        exp_disp(28, "split first digit", 7'h06, 4'b1000);
        exp_frame(36, "split 12/34", 7'h06, 7'h5B, 7'h4F, 7'h66, 8);
        wait_cyc(3);
        reset = 1'b0;

        wait_cyc(40);
        data_show = 12'd123;
        exp_busy(79, "whole load busy", 1'b1);
        exp_busy(80, "whole done", 1'b0);
        exp_disp(80, "old digit before load", 7'h4F, 4'b0010);
        exp_disp(81, "new digit after load", 7'h5B, 4'b0010);
        exp_frame(100, "whole 123", 7'h00, 7'h06, 7'h5B, 7'h4F, 8);

        wait_cyc(104);
        data_show = 12'd0;
        exp_frame(164, "whole 0", 7'h00, 7'h00, 7'h00, 7'h3F, 8);

        wait_cyc(168);
        data_show = 12'd1034;
        exp_frame(228, "1034 bright7", 7'h06, 7'h3F, 7'h4F, 7'h66, 8);
        wait_cyc(259);
        byte_status = 3'd3;
        exp_frame(260, "1034 bright3", 7'h06, 7'h3F, 7'h4F, 7'h66, 4);
        wait_cyc(291);
        byte_status = 3'd0;
        exp_frame(292, "1034 bright0", 7'h06, 7'h3F, 7'h4F, 7'h66, 1);
        wait_cyc(323);
        byte_status = 3'd7;

        // Capture at posedge 324; reset over posedges 329..330 aborts CONV_A.
        exp_busy(325, "conv before abort", 1'b1);
        exp_busy(328, "conv still running", 1'b1);
        exp_disp(328, "digits before abort", 7'h66, 4'b0001);
        exp_disp(329, "reset mid conv", 7'h00, 4'b0000);
        exp_busy(329, "abort clears busy", 1'b0);
        exp_disp(330, "reset mid conv 2", 7'h00, 4'b0000);
        exp_busy(330, "abort busy 2", 1'b0);
        exp_disp(331, "blank after abort", 7'h00, 4'b0001);
        exp_disp(338, "blank after abort s7", 7'h00, 4'b0001);
        exp_busy(332, "recapture busy", 1'b1);
        exp_busy(342, "recapture load", 1'b1);
        exp_busy(343, "recapture done", 1'b0);
        exp_frame(363, "held 7", 7'h00, 7'h00, 7'h00, 7'h07, 8);
        exp_frame(395, "new 9", 7'h00, 7'h00, 7'h00, 7'h6F, 8);
        wait_cyc(328);
        reset     = 1'b1;
        data_show = 12'd7;
        wait_cyc(330);
        reset = 1'b0;
        wait_cyc(334);
        data_show = 12'd9;

        wait_cyc(430);
        @(negedge clock);
        if (sb.size() != 0) begin
            n_cmp += sb.size();
            n_bad += sb.size();
            $display("FAIL drain: %0d expectations never checked, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
